apb_register_slave: RTL and testbench
=====================================

// Module: apb_register_slave
//
// PURPOSE
// - APB3 slave end of the audioport control path: decodes the DUT address window
//   8c000000h..8c0001B8h, holds the config register bank, emits command pulses
//   and keeps a sticky interrupt flag.
// - Sits directly downstream of the APB bus section; feeds the core datapath.
// - Zero wait states: PREADY is tied high, so every access completes in its first
//   ACCESS cycle.
//
// PARAMETERS
// - BASE_ADDR   32'h8c000000  byte address of word 0
// - NUM_REGS    111           words decoded; last word = BASE_ADDR + 4*(NUM_REGS-1) = 8c0001B8h
//
// PORTS
// - clk            in   1                 system clock; all state changes on the rising edge
// - rst            in   1                 asynchronous reset, active-high
// - PSEL           in   1                 APB select
// - PENABLE        in   1                 APB access phase
// - PWRITE         in   1                 1 = write, 0 = read
// - PADDR          in   32                APB byte address
// - PWDATA         in   32                APB write data
// - PRDATA         out  32                APB read data
// - PREADY         out  1                 constant 1
// - PSLVERR        out  1                 error response (see CONFIGURATION)
// - status_in      in   32                live core status; bits 30:0 readable
// - irq_in         in   1                 one-cycle interrupt request from core
// - cmd_start_out  out  1                 one-cycle start pulse
// - cmd_stop_out   out  1                 one-cycle stop pulse
// - cmd_clr_out    out  1                 one-cycle clear pulse
// - irq_out        out  1                 sticky interrupt to system
// - cfg_out        out  (NUM_REGS-2)*32   config words 2..NUM_REGS-1; word 2 in bits 31:0
//
// BEHAVIOUR
// - Decode:
//   - hit = PSEL && PADDR in [BASE_ADDR, BASE_ADDR+4*(NUM_REGS-1)] && PADDR[1:0]==0.
//   - idx = (PADDR-BASE_ADDR)>>2.
// - Protocol FSM (states IDLE, SETUP, ACCESS):
//   - IDLE   -> SETUP  on PSEL && !PENABLE.
//   - SETUP  -> ACCESS on PSEL && PENABLE.
//   - ACCESS -> SETUP  on PSEL && !PENABLE (back-to-back transfers).
//   - ACCESS -> IDLE   on !PSEL.
//   - PENABLE seen while in IDLE is a protocol violation: ignored, no register effect.
// - Access cycle = state SETUP with PSEL && PENABLE.
// - Write (access cycle, PWRITE, hit): committed at the rising edge that ends the access cycle.
//   - idx 0 CMD:
//     - PWDATA bits 0, 1, 2 -> cmd_start_out, cmd_stop_out, cmd_clr_out, each high for exactly
//       the 1 clock following the access edge.
//     - PWDATA bit 3 = irq_ack.
//     - Nothing is stored.
//   - idx 1 STATUS: read-only; write is discarded.
//   - idx >= 2: register[idx] <= PWDATA; visible on cfg_out in the next cycle.
// - Read (access cycle, !PWRITE, hit): PRDATA combinational in the access cycle.
//   - idx 0 returns 0.
//   - idx 1 returns {irq_out, status_in[30:0]}.
//   - idx >= 2 returns register[idx].
// - PRDATA is 0 outside hit read access cycles.
// - Interrupt:
//   - irq_out sets on irq_in and clears on a CMD write with bit 3 = 1.
//   - irq_in and ack in the same cycle: set wins, irq_out stays 1.
// - Unaligned or out-of-window accesses: no state change, PRDATA = 0.
// - Reset: all outputs except PREADY go to 0 (PRDATA, PSLVERR, cmd_*_out, irq_out, cfg_out).
//   All registers go to 0, FSM goes to IDLE, PREADY stays 1.
//   A transfer in flight when rst asserts is dropped; the master must restart with a new SETUP.
//
// CONFIGURATION
// - APB_SLVERR_EN defined:
//   - PSLVERR = 1 in the access cycle when PSEL && !hit (out-of-window or unaligned) or on a
//     write to idx 1.
//   - The register state is unaffected either way.
// - APB_SLVERR_EN undefined: PSLVERR is constant 0; such accesses are silently ignored.
//
// TESTING
// - Write 8c000008h = A5A5_0001, read it back -> PRDATA = A5A5_0001; cfg_out[31:0] = A5A5_0001
//   one cycle after the access edge.
// - Write 8c000000h = 0000_0005 -> cmd_start_out and cmd_clr_out high exactly 1 clk,
//   cmd_stop_out stays 0; a read of 8c000000h returns 0.
// - Pulse irq_in -> irq_out = 1 and STATUS bit 31 = 1. CMD write 0000_0008 in the same cycle
//   as a new irq_in -> irq_out stays 1. A later lone ack -> 0.
// - Write 8c0001B8h = FFFF_FFFF -> last cfg word set. Write 8c0001BCh -> no change, PRDATA = 0,
//   PSLVERR = 1 only with APB_SLVERR_EN.
// - Back-to-back write then read with no IDLE between -> both complete, PREADY = 1 throughout.
//   PENABLE without a prior SETUP -> ignored.
// - Assert rst during ACCESS after several writes -> all cfg_out, irq_out and pulses = 0
//   immediately, FSM returns to IDLE.

Source files
------------

// File: rtl/apb_register_slave.sv
// APB3 zero-wait-state register slave for the audioport control path: CMD pulses, STATUS, config bank.
// Optional error response is enabled by defining APB_SLVERR_EN; the default build ties PSLVERR low.
module apb_register_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8c000000,
    parameter int          NUM_REGS  = 111
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [31:0]                PADDR,
    input  logic [31:0]                PWDATA,
    output logic [31:0]                PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    input  logic [31:0]                status_in,
    input  logic                       irq_in,
    output logic                       cmd_start_out,
    output logic                       cmd_stop_out,
    output logic                       cmd_clr_out,
    output logic                       irq_out,
    output logic [(NUM_REGS-2)*32-1:0] cfg_out,
    output logic [1:0]                 fsm_state
);

    localparam int          IDX_W    = $clog2(NUM_REGS);
    localparam logic [31:0] LAST_OFS = 32'(4 * (NUM_REGS - 1));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      offset;
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             access;
    logic             wr_hit;
    logic             cmd_we;
    logic             cfg_we;
    logic [31:0]      cfg_rd;
    logic             unused_status;

    logic [31:0] regs [2:NUM_REGS-1];

    // Unsigned offset wraps for addresses below the base, so one upper-bound test covers both ends.
    assign offset = PADDR - BASE_ADDR;
    assign hit    = PSEL && (offset <= LAST_OFS) && (offset[1:0] == 2'b00);
    assign idx    = offset[IDX_W+1:2];

    assign unused_status = status_in[31];

    // Valid/ready: the master holds PSEL with PENABLE low for one setup cycle, then raises PENABLE;
    // PREADY is always high, so the transfer completes at the edge ending that first PENABLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (PENABLE) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (!PENABLE) begin
                    state_next = SETUP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fsm_state = state;
    assign access    = (state == SETUP) && PSEL && PENABLE;
    assign wr_hit    = access && PWRITE && hit;
    assign cmd_we    = wr_hit && (idx == IDX_W'(0));
    assign cfg_we    = wr_hit && (idx >= IDX_W'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_start_out <= 1'b0;
            cmd_stop_out  <= 1'b0;
            cmd_clr_out   <= 1'b0;
        end else begin
            cmd_start_out <= cmd_we && PWDATA[0];
            cmd_stop_out  <= cmd_we && PWDATA[1];
            cmd_clr_out   <= cmd_we && PWDATA[2];
        end
    end

    // A new request in the same cycle as an acknowledge must not be lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_out <= 1'b0;
        end else if (irq_in) begin
            irq_out <= 1'b1;
        end else if (cmd_we && PWDATA[3]) begin
            irq_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 2; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 2; i < NUM_REGS; i++) begin
                if (cfg_we && (idx == IDX_W'(i))) begin
                    regs[i] <= PWDATA;
                end
            end
        end
    end

    always_comb begin
        cfg_out = '0;
        cfg_rd  = '0;
        for (int i = 2; i < NUM_REGS; i++) begin
            cfg_out[(i-2)*32 +: 32] = regs[i];
            if (idx == IDX_W'(i)) begin
                cfg_rd = regs[i];
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE && hit) begin
            if (idx == IDX_W'(0)) begin
                PRDATA = '0;
            end else if (idx == IDX_W'(1)) begin
                PRDATA = {irq_out, status_in[30:0]};
            end else begin
                PRDATA = cfg_rd;
            end
        end
    end

    assign PREADY = 1'b1;

`ifdef APB_SLVERR_EN
    assign PSLVERR = access && (!hit || (PWRITE && (idx == IDX_W'(1))));
`else
    assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_register_slave.sv
// Directed bench for apb_register_slave: transaction-level model plus per-cycle output compare.
module tb_apb_register_slave;

    localparam int          N    = 111;
    localparam int          CW   = (N - 2) * 32;
    localparam logic [31:0] BASE = 32'h8c000000;

    logic          clk;
    logic          rst;
    logic          PSEL, PENABLE, PWRITE;
    logic [31:0]   PADDR, PWDATA, PRDATA;
    logic          PREADY, PSLVERR;
    logic [31:0]   status_in;
    logic          irq_in;
    logic          cmd_start_out, cmd_stop_out, cmd_clr_out, irq_out;
    logic [CW-1:0] cfg_out;
    logic [1:0]    fsm_state;

    int vectors     = 0;
    int miscompares = 0;

    // bench's own view of the current transfer
    logic        tb_acc;
    logic        tb_hit;
    int          tb_idx;
    logic [31:0] last_rd;
    logic        last_err;

    // behavioural model
    logic [31:0] m_cfg [0:N-1];
    logic        m_irq, m_start, m_stop, m_clr;

    logic exp_err_en;

    apb_register_slave dut (
        .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .status_in(status_in), .irq_in(irq_in), .cmd_start_out(cmd_start_out),
        .cmd_stop_out(cmd_stop_out), .cmd_clr_out(cmd_clr_out), .irq_out(irq_out),
        .cfg_out(cfg_out), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'(4 * (N - 1))) && (a[1:0] == 2'b00);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: committed effects of each bench-recognised access cycle at the rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_cfg[i] <= '0;
            m_irq   <= 1'b0;
            m_start <= 1'b0;
            m_stop  <= 1'b0;
            m_clr   <= 1'b0;
        end else begin
            m_start <= tb_acc && PWRITE && tb_hit && (tb_idx == 0) && PWDATA[0];
            m_stop  <= tb_acc && PWRITE && tb_hit && (tb_idx == 0) && PWDATA[1];
            m_clr   <= tb_acc && PWRITE && tb_hit && (tb_idx == 0) && PWDATA[2];
            if (tb_acc && PWRITE && tb_hit && (tb_idx >= 2)) m_cfg[tb_idx] <= PWDATA;
            if (irq_in) m_irq <= 1'b1;
            else if (tb_acc && PWRITE && tb_hit && (tb_idx == 0) && PWDATA[3]) m_irq <= 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] erd;
        logic        eerr;
        logic [CW-1:0] ecfg;
        int          bad;
        erd = '0;
        if (tb_acc && !PWRITE && tb_hit) begin
            if (tb_idx == 0) erd = '0;
            else if (tb_idx == 1) erd = {m_irq, status_in[30:0]};
            else erd = m_cfg[tb_idx];
        end
        eerr = exp_err_en && tb_acc && (!tb_hit || (PWRITE && (tb_idx == 1)));
        for (int i = 2; i < N; i++) ecfg[(i-2)*32 +: 32] = m_cfg[i];
        check("prdata", PRDATA, erd);
        check("pslverr", {31'b0, PSLVERR}, {31'b0, eerr});
        check("pready", {31'b0, PREADY}, 32'd1);
        check("irq_out", {31'b0, irq_out}, {31'b0, m_irq});
        check("cmd_pulses", {29'b0, cmd_clr_out, cmd_stop_out, cmd_start_out},
              {29'b0, m_clr, m_stop, m_start});
        vectors++;
        if (cfg_out !== ecfg) begin
            miscompares++;
            bad = 0;
            for (int i = N - 1; i >= 2; i--) if (cfg_out[(i-2)*32 +: 32] !== ecfg[(i-2)*32 +: 32]) bad = i;
            $display("FAIL cfg_out word %0d: got %h expected %h at %0t", bad,
                     cfg_out[(bad-2)*32 +: 32], ecfg[(bad-2)*32 +: 32], $time);
        end
    end

    // Called at edge+1; leaves PSEL high with PENABLE low so a following call is back-to-back.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data, input bit irq_acc);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; tb_acc = 1'b0;
        @(posedge clk); #1;
        PENABLE = 1'b1; tb_acc = 1'b1; tb_hit = in_window(addr); tb_idx = idx_of(addr);
        if (irq_acc) irq_in = 1'b1;
        @(negedge clk);
        last_rd = PRDATA; last_err = PSLVERR;
        @(posedge clk); #1;
        PENABLE = 1'b0; tb_acc = 1'b0; irq_in = 1'b0; tb_hit = 1'b0; tb_idx = 0;
    endtask

    task automatic idle(input int n);
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] cfg_writes [6] = '{32'h0000_0001, 32'hFFFF_0000, 32'h1357_9BDF,
                                    32'h8000_0000, 32'h0F0F_F0F0, 32'hDEAD_BEEF};
    logic [31:0] cfg_addrs  [6] = '{32'h8c00_0010, 32'h8c00_0014, 32'h8c00_0100,
                                    32'h8c00_01B4, 32'h8c00_0044, 32'h8c00_00C8};

    initial begin
`ifdef APB_SLVERR_EN
        exp_err_en = 1'b1;
`else
        exp_err_en = 1'b0;
`endif
        rst = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        status_in = 32'hFFFF_1234; irq_in = 0;
        tb_acc = 0; tb_hit = 0; tb_idx = 0; last_rd = 0; last_err = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {30'b0, fsm_state}, 32'd0);
        check("reset_cfg0", cfg_out[31:0], 32'd0);
        rst = 1'b0;
        idle(2);

        // config write and readback
        xfer(1, 32'h8c00_0008, 32'hA5A5_0001, 0); idle(0);
        check("cfg0_after_write", cfg_out[31:0], 32'hA5A5_0001);
        check("model_cfg2", m_cfg[2], 32'hA5A5_0001);
        xfer(0, 32'h8c00_0008, 0, 0); idle(1);
        check("readback_cfg2", last_rd, 32'hA5A5_0001);

        // command pulses
        xfer(1, 32'h8c00_0000, 32'h0000_0005, 0); idle(0);
        check("pulse_cycle", {29'b0, cmd_clr_out, cmd_stop_out, cmd_start_out}, 32'd5);
        idle(1);
        check("pulse_gone", {29'b0, cmd_clr_out, cmd_stop_out, cmd_start_out}, 32'd0);
        xfer(0, 32'h8c00_0000, 0, 0); idle(1);
        check("read_cmd", last_rd, 32'd0);

        // interrupt set / simultaneous ack / lone ack
        xfer(0, 32'h8c00_0004, 0, 0); idle(0);
        check("status_no_irq", last_rd, 32'h7FFF_1234);
        irq_in = 1'b1; @(posedge clk); #1; irq_in = 1'b0;
        check("irq_set", {31'b0, irq_out}, 32'd1);
        xfer(0, 32'h8c00_0004, 0, 0); idle(0);
        check("status_irq", last_rd, 32'hFFFF_1234);
        xfer(1, 32'h8c00_0000, 32'h0000_0008, 1); idle(1);
        check("irq_set_wins", {31'b0, irq_out}, 32'd1);
        xfer(1, 32'h8c00_0000, 32'h0000_0008, 0); idle(1);
        check("irq_acked", {31'b0, irq_out}, 32'd0);

        // window edges, unaligned, below base, STATUS write
        xfer(1, 32'h8c00_01B8, 32'hFFFF_FFFF, 0); idle(1);
        check("last_word", cfg_out[CW-1 -: 32], 32'hFFFF_FFFF);
        xfer(1, 32'h8c00_01BC, 32'h1234_5678, 0); idle(0);
        check("oow_write_err", {31'b0, last_err}, {31'b0, exp_err_en});
        xfer(0, 32'h8c00_01BC, 0, 0); idle(0);
        check("oow_read", last_rd, 32'd0);
        xfer(1, 32'h8c00_000A, 32'h0BAD_0BAD, 0); idle(0);
        check("unaligned_err", {31'b0, last_err}, {31'b0, exp_err_en});
        xfer(1, 32'h8BFF_FFFC, 32'h0BAD_0BAD, 0); idle(0);
        xfer(1, 32'h8c00_0004, 32'hFFFF_FFFF, 0); idle(0);
        check("status_write_err", {31'b0, last_err}, {31'b0, exp_err_en});
        xfer(0, 32'h8c00_0008, 0, 0); idle(1);
        check("cfg2_untouched", last_rd, 32'hA5A5_0001);

        // back-to-back write then read, no IDLE between
        xfer(1, 32'h8c00_000C, 32'hC0DE_0003, 0);
        xfer(0, 32'h8c00_000C, 0, 0); idle(1);
        check("b2b_read", last_rd, 32'hC0DE_0003);

        // PENABLE without SETUP is ignored
        PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 32'h8c00_0018; PWDATA = 32'h0000_1234;
        repeat (2) begin
            @(posedge clk); #1;
        end
        idle(1);
        xfer(0, 32'h8c00_0018, 0, 0); idle(1);
        check("no_setup_ignored", last_rd, 32'd0);

        // table of config writes, then reads checked by the per-cycle compare
        for (int i = 0; i < 6; i++) xfer(1, cfg_addrs[i], cfg_writes[i], 0);
        for (int i = 0; i < 6; i++) xfer(0, cfg_addrs[i], 0, 0);
        idle(1);
        check("table_last_read", last_rd, 32'hDEAD_BEEF);

        // reset while the FSM is in ACCESS with pulses and irq active
        irq_in = 1'b1; @(posedge clk); #1; irq_in = 1'b0;
        xfer(1, 32'h8c00_0000, 32'h0000_0001, 0);
        #1;
        check("pre_reset_pulse", {31'b0, cmd_start_out}, 32'd1);
        PENABLE = 1; PADDR = 32'h8c00_0008; PWDATA = 32'hDEAD_BEEF;
        rst = 1'b1;
        #1;
        check("rst_cfg_any", {31'b0, |cfg_out}, 32'd0);
        check("rst_irq", {31'b0, irq_out}, 32'd0);
        check("rst_pulse", {31'b0, cmd_start_out}, 32'd0);
        check("rst_fsm", {30'b0, fsm_state}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("dropped_xfer_fsm", {30'b0, fsm_state}, 32'd0);
        idle(1);
        xfer(0, 32'h8c00_0008, 0, 0); idle(2);
        check("dropped_xfer_cfg", last_rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
